// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Fetch front-end. Owns the fetch PC, issues one outstanding word
//            fetch over req/gnt/rvalid, buffers words in a small FWFT prefetch
//            FIFO and hands {instruction, PC} to decode. Redirects flush the
//            FIFO and discard stale in-flight responses.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t             r_state;
  logic [31:0]        r_fetch_pc;
  logic [31:0]        r_req_pc;
  logic [31:0]        r_mem_data [DEPTH];
  logic [31:0]        r_mem_pc   [DEPTH];
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [31:0]        r_head_data;
  logic [31:0]        r_head_pc;

  logic               w_grant;
  logic               w_push;
  logic               w_pop;
  logic [31:0]        w_redirect_pc;
  logic [c_CNT_W-1:0] w_cnt_after_pop;
  logic [c_CNT_W-1:0] w_cnt_next;
  logic [c_PTR_W-1:0] w_rd_next;
  logic [31:0]        w_next_head_data;
  logic [31:0]        w_next_head_pc;

  assign imem_req      = (r_state == S_REQ) && (r_count < c_DEPTH);
  assign imem_addr     = r_fetch_pc;
  assign inst_valid    = (r_count != '0);
  assign inst_data     = r_head_data;
  assign inst_pc       = r_head_pc;

  assign w_grant       = imem_req & imem_gnt;
  // A response arriving together with a redirect belongs to the old stream.
  assign w_push        = (r_state == S_WAIT) & imem_rvalid & ~redirect;
  assign w_pop         = inst_valid & inst_ready;
  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};

  assign w_cnt_after_pop = r_count - c_CNT_W'(w_pop);
  assign w_cnt_next      = w_cnt_after_pop + c_CNT_W'(w_push);
  assign w_rd_next       = r_rd_ptr + c_PTR_W'(w_pop);

  // Next head: if the FIFO drains to empty this cycle, only the incoming word can be the head.
  always_comb begin
    w_next_head_data = r_mem_data[w_rd_next];
    w_next_head_pc   = r_mem_pc[w_rd_next];
    if (w_cnt_after_pop == '0) begin
      w_next_head_data = imem_rdata;
      w_next_head_pc   = r_req_pc;
    end
  end

  // Fetch FSM: PC sequencing, single outstanding request, redirect handling.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
          if (redirect) r_fetch_pc <= w_redirect_pc;
        end
        S_REQ: begin
          if (redirect) begin
            // A granted request is already in flight; its response must be drained.
            r_fetch_pc <= w_redirect_pc;
            r_state    <= w_grant ? S_DRAIN : S_REQ;
          end else if (w_grant) begin
            r_req_pc   <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + 32'd4;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect) r_fetch_pc <= w_redirect_pc;
          if (imem_rvalid)   r_state <= S_REQ;
          else if (redirect) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (redirect)    r_fetch_pc <= w_redirect_pc;
          if (imem_rvalid) r_state    <= S_REQ;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO control and registered head; head holds its value while the FIFO is empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_head_data <= '0;
      r_head_pc   <= '0;
    end else if (redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= w_rd_next;
      r_wr_ptr <= r_wr_ptr + c_PTR_W'(w_push);
      r_count  <= w_cnt_next;
      if (w_cnt_next != '0) begin
        r_head_data <= w_next_head_data;
        r_head_pc   <= w_next_head_pc;
      end
    end
  end

  // FIFO storage; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= imem_rdata;
      r_mem_pc[r_wr_ptr]   <= r_req_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Self-checking bench for instr_fetch_unit with a behavioural
//            variable-latency instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  int total = 0;
  int bad   = 0;

  // memory model state
  int          lat = 1;
  logic        mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_data  (inst_data),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: advance the memory model from what the DUT saw at the edge.
  task automatic step();
    logic        g;
    logic [31:0] a;
    g = imem_req && imem_gnt;
    a = imem_addr;
    @(posedge clk);
    #1;
    if (imem_rvalid) begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hBAD0_BAD0;
      mem_pend    = 1'b0;
    end else if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr);
      end
    end
    if (g) begin
      mem_pend = 1'b1;
      mem_addr = a;
      mem_cnt  = lat - 1;
      if (lat == 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(a);
      end
    end
  endtask

  task automatic mem_clear();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hBAD0_BAD0;
    mem_pend    = 1'b0;
    mem_cnt     = 0;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    redirect = 1'b0;
    mem_clear();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b1;
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (!imem_req && n < 20) begin
      step();
      n++;
    end
    check({nm, "_req_seen"}, 32'(imem_req), 32'd1);
  endtask

  task automatic wait_req_addr(input logic [31:0] addr, input string nm);
    int n = 0;
    while (!(imem_req && imem_addr == addr) && n < 20) begin
      step();
      n++;
    end
    check({nm, "_req_addr"}, imem_addr, addr);
  endtask

  task automatic wait_rvalid(input string nm);
    int n = 0;
    while (!imem_rvalid && n < 20) begin
      step();
      n++;
    end
    check({nm, "_rvalid_seen"}, 32'(imem_rvalid), 32'd1);
  endtask

  task automatic wait_valid(input logic [31:0] epc, input string nm);
    int n = 0;
    while (!inst_valid && n < 20) begin
      step();
      n++;
    end
    if (!inst_valid) begin
      check({nm, "_valid_timeout"}, 32'(inst_valid), 32'd1);
    end else begin
      check({nm, "_pc"}, inst_pc, epc);
      check({nm, "_data"}, inst_data, mem_word(epc));
    end
  endtask

  typedef struct {
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        have;
  } vec_t;

  vec_t tv [18];

  initial begin
    // rows: ready, exp req, exp addr, exp valid, exp head pc, head data defined
    tv[0]  = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 1'b0};
    tv[1]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 1'b0};
    tv[2]  = '{1'b1, 1'b0, 32'h04, 1'b0, 32'h00, 1'b0};
    tv[3]  = '{1'b1, 1'b1, 32'h04, 1'b1, 32'h00, 1'b1};
    tv[4]  = '{1'b1, 1'b0, 32'h08, 1'b0, 32'h00, 1'b1};
    tv[5]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h04, 1'b1};
    tv[6]  = '{1'b1, 1'b0, 32'h0C, 1'b0, 32'h04, 1'b1};
    tv[7]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h08, 1'b1};
    tv[8]  = '{1'b1, 1'b0, 32'h10, 1'b0, 32'h08, 1'b1};
    tv[9]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h0C, 1'b1};
    tv[10] = '{1'b0, 1'b0, 32'h14, 1'b1, 32'h0C, 1'b1};
    tv[11] = '{1'b0, 1'b0, 32'h14, 1'b1, 32'h0C, 1'b1};
    tv[12] = '{1'b0, 1'b0, 32'h14, 1'b1, 32'h0C, 1'b1};
    tv[13] = '{1'b0, 1'b0, 32'h14, 1'b1, 32'h0C, 1'b1};
    tv[14] = '{1'b1, 1'b0, 32'h14, 1'b1, 32'h0C, 1'b1};
    tv[15] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h10, 1'b1};
    tv[16] = '{1'b1, 1'b0, 32'h18, 1'b0, 32'h10, 1'b1};
    tv[17] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h14, 1'b1};

    reset_n     = 1'b0;
    imem_gnt    = 1'b1;
    inst_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    mem_clear();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("rst_req",   32'(imem_req),   32'd0);
    check("rst_addr",  imem_addr,       32'h0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_data",  inst_data,       32'h0);
    check("rst_pc",    inst_pc,         32'h0);
    reset_n = 1'b1;

    // streaming, then back-pressure filling the FIFO and release
    lat = 1;
    for (int i = 0; i < 18; i++) begin
      inst_ready = tv[i].ready;
      check($sformatf("tv%0d_req", i),   32'(imem_req),   32'(tv[i].e_req));
      check($sformatf("tv%0d_addr", i),  imem_addr,       tv[i].e_addr);
      check($sformatf("tv%0d_valid", i), 32'(inst_valid), 32'(tv[i].e_valid));
      check($sformatf("tv%0d_pc", i),    inst_pc,         tv[i].e_pc);
      check($sformatf("tv%0d_data", i),  inst_data,
            tv[i].have ? mem_word(tv[i].e_pc) : 32'h0);
      step();
    end

    // redirect while waiting on a slow response
    do_reset();
    lat = 3;
    inst_ready = 1'b1;
    wait_req("t3");
    step();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    redirect = 1'b0;
    check("t3_drain_req",  32'(imem_req), 32'd0);
    check("t3_drain_addr", imem_addr,     32'h100);
    wait_req("t3b");
    check("t3_next_addr", imem_addr, 32'h100);
    wait_valid(32'h100, "t3_first");

    // redirect in the same cycle as the grant for 0x8
    do_reset();
    lat = 1;
    inst_ready = 1'b1;
    wait_req_addr(32'h8, "t4");
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    redirect = 1'b0;
    check("t4_drain_req",  32'(imem_req),   32'd0);
    check("t4_drain_addr", imem_addr,       32'h200);
    check("t4_flushed",    32'(inst_valid), 32'd0);
    wait_req("t4b");
    check("t4_next_addr", imem_addr, 32'h200);
    wait_valid(32'h200, "t4_first");

    // redirect together with rvalid while the FIFO holds data and decode pops
    do_reset();
    lat = 3;
    inst_ready = 1'b0;
    wait_rvalid("t5a");
    step();
    wait_rvalid("t5b");
    check("t5_pre_valid", 32'(inst_valid), 32'd1);
    check("t5_pre_pc",    inst_pc,         32'h0);
    inst_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0043;
    step();
    redirect = 1'b0;
    check("t5_flushed", 32'(inst_valid), 32'd0);
    check("t5_req",     32'(imem_req),   32'd1);
    check("t5_addr",    imem_addr,       32'h40);
    wait_valid(32'h40, "t5_first");

    // asynchronous reset mid-WAIT with one entry buffered
    do_reset();
    lat = 3;
    inst_ready = 1'b0;
    wait_rvalid("t6");
    step();
    check("t6_req_before_gnt", 32'(imem_req), 32'd1);
    step();
    check("t6_wait_req",   32'(imem_req),   32'd0);
    check("t6_wait_valid", 32'(inst_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(inst_valid), 32'd0);
    check("t6_rst_req",   32'(imem_req),   32'd0);
    check("t6_rst_addr",  imem_addr,       32'h0);
    check("t6_rst_pc",    inst_pc,         32'h0);
    mem_clear();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_req("t6b");
    check("t6_restart_addr", imem_addr, 32'h0);
    inst_ready = 1'b1;
    wait_valid(32'h0, "t6_first");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
